// File: rtl/ram_ring_addresser.sv
// rtl/ram_ring_addresser.sv - write/read pointer generator over a circular RAM region
module ram_ring_addresser #(
    parameter int ADDR_W    = 11,
    parameter int DEPTH     = 2048,
    parameter int DOWN      = 1,
    parameter int OVERWRITE = 1
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_ena,
    input  logic              rd_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    // Last legal ring index; the wrap uses this rather than the all-ones address
    // so non-power-of-2 depths never touch words beyond the ring.
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] START     = (DOWN != 0) ? LAST : '0;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic              OVW       = (OVERWRITE != 0);

    logic flush;
    logic rd_acc;
    logic wr_acc;
    logic drop_oldest;

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] p);
        if (DOWN != 0) begin
            return (p == '0) ? LAST : p - ADDR_W'(1);
        end else begin
            return (p == LAST) ? '0 : p + ADDR_W'(1);
        end
    endfunction

    // Accept decisions: a flush cycle accepts nothing; a read frees a slot so a
    // simultaneous write is always allowed, even when full and not overwriting.
    always_comb begin
        flush       = reset | clear;
        full        = (count == DEPTH_CNT);
        empty       = (count == '0);
        rd_acc      = rd_ena & ~empty & ~flush;
        wr_acc      = wr_ena & ~flush & (~full | rd_acc | OVW);
        wr_we       = wr_acc;
        drop_oldest = wr_acc & full & ~rd_acc;
    end

    // Pointer, fill-count and flag state; reset and clear have identical effect.
    always_ff @(posedge clk_2) begin
        if (reset || clear) begin
            wr_addr  <= START;
            rd_addr  <= START;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_addr <= advance(wr_addr);
            end
            // Overwriting while full pushes the read pointer past the lost word.
            if (rd_acc || drop_oldest) begin
                rd_addr <= advance(rd_addr);
            end
            if (wr_acc && !rd_acc && !full) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - (ADDR_W + 1)'(1);
            end
            rd_valid <= rd_acc;
            if (wr_ena && full && !rd_acc) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_ring_addresser.sv
// tb/tb_ram_ring_addresser.sv - self-checking bench for ram_ring_addresser
module tb_ram_ring_addresser;

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic reset  = 1'b1;
    logic clear  = 1'b0;
    logic wr_ena = 1'b0;
    logic rd_ena = 1'b0;

    int checks = 0;
    int passes = 0;
    bit checking = 1'b0;

    // u0: defaults (2048 deep, down, overwrite)
    logic [10:0] wa0, ra0;
    logic [11:0] cn0;
    logic        we0, rv0, fu0, em0, ov0;
    // u1: 5 deep, up, overwrite
    logic [2:0]  wa1, ra1;
    logic [3:0]  cn1;
    logic        we1, rv1, fu1, em1, ov1;
    // u2: 4 deep, down, overwrite
    logic [2:0]  wa2, ra2;
    logic [3:0]  cn2;
    logic        we2, rv2, fu2, em2, ov2;
    // u3: 4 deep, down, block when full
    logic [2:0]  wa3, ra3;
    logic [3:0]  cn3;
    logic        we3, rv3, fu3, em3, ov3;

    ram_ring_addresser u0 (
        .clk_2(clk_2), .reset(reset), .clear(clear), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .wr_addr(wa0), .wr_we(we0), .rd_addr(ra0), .rd_valid(rv0), .count(cn0),
        .full(fu0), .empty(em0), .overflow(ov0)
    );

    ram_ring_addresser #(.ADDR_W(3), .DEPTH(5), .DOWN(0), .OVERWRITE(1)) u1 (
        .clk_2(clk_2), .reset(reset), .clear(clear), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .wr_addr(wa1), .wr_we(we1), .rd_addr(ra1), .rd_valid(rv1), .count(cn1),
        .full(fu1), .empty(em1), .overflow(ov1)
    );

    ram_ring_addresser #(.ADDR_W(3), .DEPTH(4), .DOWN(1), .OVERWRITE(1)) u2 (
        .clk_2(clk_2), .reset(reset), .clear(clear), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .wr_addr(wa2), .wr_we(we2), .rd_addr(ra2), .rd_valid(rv2), .count(cn2),
        .full(fu2), .empty(em2), .overflow(ov2)
    );

    ram_ring_addresser #(.ADDR_W(3), .DEPTH(4), .DOWN(1), .OVERWRITE(0)) u3 (
        .clk_2(clk_2), .reset(reset), .clear(clear), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .wr_addr(wa3), .wr_we(we3), .rd_addr(ra3), .rd_valid(rv3), .count(cn3),
        .full(fu3), .empty(em3), .overflow(ov3)
    );

    // Model: each ring tracked as total words written/retired; addresses follow
    // from the step totals modulo the depth.
    int md[4]  = '{2048, 5, 4, 4};
    int mdn[4] = '{1, 0, 1, 1};
    int mow[4] = '{1, 1, 1, 0};
    int ws[4]  = '{0, 0, 0, 0};
    int rs[4]  = '{0, 0, 0, 0};
    bit mov[4] = '{0, 0, 0, 0};
    bit mrv[4] = '{0, 0, 0, 0};

    function automatic int ring_addr(input int i, input int steps);
        return (mdn[i] != 0) ? (md[i] - 1 - (steps % md[i])) : (steps % md[i]);
    endfunction

    function automatic bit m_full(input int i);
        return (ws[i] - rs[i]) == md[i];
    endfunction

    function automatic bit m_empty(input int i);
        return ws[i] == rs[i];
    endfunction

    function automatic bit m_racc(input int i);
        return rd_ena && !reset && !clear && !m_empty(i);
    endfunction

    function automatic bit m_wacc(input int i);
        return wr_ena && !reset && !clear && (!m_full(i) || m_racc(i) || mow[i] != 0);
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s u%0d: got %0d, expected %0d at %0t", name, i, act, exp, $time);
    endtask

    always @(posedge clk_2) begin : model_update
        bit r_a, w_a, f_l;
        for (int i = 0; i < 4; i++) begin
            r_a = m_racc(i);
            w_a = m_wacc(i);
            f_l = m_full(i);
            if (reset || clear) begin
                ws[i]  = 0;
                rs[i]  = 0;
                mov[i] = 1'b0;
                mrv[i] = 1'b0;
            end else begin
                if (w_a) ws[i]++;
                if (r_a || (w_a && f_l)) rs[i]++;
                if (wr_ena && f_l && !r_a) mov[i] = 1'b1;
                mrv[i] = r_a;
            end
        end
    end

    always @(negedge clk_2) begin : compare
        int a_wa, a_ra, a_cn, a_we, a_rv, a_fu, a_em, a_ov;
        if (checking) begin
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0: begin a_wa = int'(wa0); a_ra = int'(ra0); a_cn = int'(cn0); a_we = int'(we0);
                             a_rv = int'(rv0); a_fu = int'(fu0); a_em = int'(em0); a_ov = int'(ov0); end
                    1: begin a_wa = int'(wa1); a_ra = int'(ra1); a_cn = int'(cn1); a_we = int'(we1);
                             a_rv = int'(rv1); a_fu = int'(fu1); a_em = int'(em1); a_ov = int'(ov1); end
                    2: begin a_wa = int'(wa2); a_ra = int'(ra2); a_cn = int'(cn2); a_we = int'(we2);
                             a_rv = int'(rv2); a_fu = int'(fu2); a_em = int'(em2); a_ov = int'(ov2); end
                    default: begin a_wa = int'(wa3); a_ra = int'(ra3); a_cn = int'(cn3); a_we = int'(we3);
                             a_rv = int'(rv3); a_fu = int'(fu3); a_em = int'(em3); a_ov = int'(ov3); end
                endcase
                chk("wr_addr", i, a_wa, ring_addr(i, ws[i]));
                chk("rd_addr", i, a_ra, ring_addr(i, rs[i]));
                chk("count", i, a_cn, ws[i] - rs[i]);
                chk("wr_we", i, a_we, int'(m_wacc(i)));
                chk("rd_valid", i, a_rv, int'(mrv[i]));
                chk("full", i, a_fu, int'(m_full(i)));
                chk("empty", i, a_em, int'(m_empty(i)));
                chk("overflow", i, a_ov, int'(mov[i]));
            end
        end
    end

    task automatic drive(input bit w, input bit r, input bit c, input bit rst);
        @(posedge clk_2);
        #1;
        wr_ena = w;
        rd_ena = r;
        clear  = c;
        reset  = rst;
        @(negedge clk_2);
    endtask

    initial begin
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        checking = 1'b1;
        drive(0, 0, 0, 0);
        chk("lit_reset_wr_addr", 0, int'(wa0), 2047);
        chk("lit_reset_rd_addr", 0, int'(ra0), 2047);
        chk("lit_reset_count", 0, int'(cn0), 0);
        chk("lit_reset_empty", 0, int'(em0), 1);
        chk("lit_reset_wr_we", 0, int'(we0), 0);
        chk("lit_reset_up_start", 1, int'(wa1), 0);

        repeat (3) drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("lit_3w_wr_addr", 0, int'(wa0), 2044);
        chk("lit_3w_count", 0, int'(cn0), 3);
        drive(1, 0, 0, 0);
        chk("lit_block_w5_we", 3, int'(we3), 0);
        drive(0, 0, 0, 0);
        chk("lit_5w_wrap_addr", 1, int'(wa1), 0);
        chk("lit_5w_full", 1, int'(fu1), 1);
        chk("lit_block_hold_addr", 3, int'(wa3), 3);
        drive(1, 0, 0, 0);
        chk("lit_block_w6_we", 3, int'(we3), 0);
        drive(0, 0, 0, 0);
        chk("lit_ovw_count", 2, int'(cn2), 4);
        chk("lit_ovw_overflow", 2, int'(ov2), 1);
        chk("lit_ovw_rd_addr", 2, int'(ra2), 1);
        chk("lit_ovw_wr_addr", 2, int'(wa2), 1);
        chk("lit_block_wr_addr", 3, int'(wa3), 3);
        chk("lit_block_overflow", 3, int'(ov3), 1);
        chk("lit_block_count", 3, int'(cn3), 4);

        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("lit_clear_overflow", 2, int'(ov2), 0);
        repeat (4) drive(1, 0, 0, 0);
        repeat (3) begin
            drive(1, 1, 0, 0);
            chk("lit_full_rw_we", 3, int'(we3), 1);
            chk("lit_full_rw_full", 3, int'(fu3), 1);
        end
        drive(0, 0, 0, 0);
        chk("lit_full_rw_count", 3, int'(cn3), 4);
        chk("lit_full_rw_ovf", 3, int'(ov3), 0);
        chk("lit_full_rw_ovf", 2, int'(ov2), 0);

        drive(0, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 0);
        repeat (5) drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("lit_5r_empty", 1, int'(em1), 1);
        chk("lit_5r_rd_valid", 1, int'(rv1), 1);
        chk("lit_5r_rd_addr", 1, int'(ra1), 0);
        drive(0, 0, 0, 0);
        chk("lit_empty_rd_valid", 1, int'(rv1), 0);

        drive(0, 0, 1, 0);
        drive(1, 1, 0, 0);
        chk("lit_empty_rw_we", 1, int'(we1), 1);
        drive(0, 0, 0, 0);
        chk("lit_empty_rw_count", 0, int'(cn0), 1);
        chk("lit_empty_rw_count", 1, int'(cn1), 1);
        chk("lit_empty_rw_rd_valid", 1, int'(rv1), 0);

        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0);
            repeat (10) drive(1, 0, 0, 0);
            drive(0, 1, 0, 0);
            drive(1, 1, k == 0, k == 1);
            chk("lit_flush_wr_we", 0, int'(we0), 0);
            chk("lit_flush_wr_we", 2, int'(we2), 0);
            chk("lit_pre_flush_ovf", 2, int'(ov2), 1);
            chk("lit_pre_flush_rd_valid", 0, int'(rv0), 1);
            drive(0, 0, 0, 0);
            chk("lit_flush_wr_addr", 0, int'(wa0), 2047);
            chk("lit_flush_rd_addr", 0, int'(ra0), 2047);
            chk("lit_flush_count", 0, int'(cn0), 0);
            chk("lit_flush_rd_valid", 0, int'(rv0), 0);
            chk("lit_flush_ovf", 2, int'(ov2), 0);
            chk("lit_flush_empty", 2, int'(em2), 1);
            chk("lit_flush_up_start", 1, int'(wa1), 0);
        end

        drive(0, 0, 0, 0);
        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
